// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: drives ROM line address and queues returned
// words with their PCs for decode over a valid/ready handshake.
module instr_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [31:0]                rom_addr,
    input  logic [127:0]               rom_data,
    input  logic                       jmp_en,
    input  logic [31:0]                jmp_addr,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    word_off;
    logic [2:0]    n_words;
    logic [SW-1:0] fill_sum;
    logic          can_fetch;
    logic          do_write;
    logic          do_pop;

    assign word_off  = fetch_pc_q[3:2];
    assign n_words   = 3'd4 - {1'b0, word_off};
    // Only occupancy at cycle start counts; a same-cycle pop frees no room.
    assign fill_sum  = SW'(count_q) + SW'(n_words);
    assign can_fetch = (fill_sum <= SW'(DEPTH));

    assign instr_valid = (count_q != '0);
    assign do_write    = !jmp_en && can_fetch;
    assign do_pop      = !jmp_en && instr_valid && instr_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (jmp_en) begin
            fetch_pc_d = jmp_addr & ~32'h3;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (do_write) begin
                fetch_pc_d = {fetch_pc_q[31:4] + 28'd1, 4'b0000};
                tail_d     = tail_q + PW'(n_words);
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q
                    + (do_write ? CW'(n_words) : CW'(0))
                    - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (do_write && (3'(k) < n_words)) begin
                instr_mem[tail_q + PW'(k)] <=
                    rom_data[32*(int'(word_off) + k) +: 32];
                pc_mem[tail_q + PW'(k)] <= fetch_pc_q + 32'(4 * k);
            end
        end
    end

    assign rom_addr    = fetch_pc_q;
    assign queue_count = count_q;
    assign instr       = instr_valid ? instr_mem[head_q] : 32'h0;
    assign instr_pc    = instr_valid ? pc_mem[head_q]    : 32'h0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table followed by
// randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

    logic         clk;
    logic         rst;
    logic [31:0]  rom_addr;
    logic [127:0] rom_data;
    logic         jmp_en;
    logic [31:0]  jmp_addr;
    logic         instr_ready;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic [3:0]   queue_count;

    int checks = 0;
    int errors = 0;

    instr_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .queue_count (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // ROM: word k of the addressed line
    always_comb begin
        rom_data = '0;
        for (int k = 0; k < 4; k++)
            rom_data[32*k +: 32] = rom_word({rom_addr[31:4], 4'b0000} + 32'(4 * k));
    end

    // Reference model: a plain queue of (instr, pc) plus the fetch PC
    logic [31:0] mq_ins [$];
    logic [31:0] mq_pc  [$];
    logic [31:0] m_pc;

    task automatic model_update();
        int n;
        bit fits;
        bit pop;
        if (rst) begin
            m_pc = 32'h0;
            mq_ins.delete();
            mq_pc.delete();
        end else if (jmp_en) begin
            m_pc = jmp_addr & ~32'h3;
            mq_ins.delete();
            mq_pc.delete();
        end else begin
            n    = 4 - int'(m_pc[3:2]);
            fits = (mq_ins.size() + n) <= 8;
            pop  = (mq_ins.size() != 0) && instr_ready;
            if (pop) begin
                void'(mq_ins.pop_front());
                void'(mq_pc.pop_front());
            end
            if (fits) begin
                for (int k = 0; k < n; k++) begin
                    mq_ins.push_back(rom_word(m_pc + 32'(4 * k)));
                    mq_pc.push_back(m_pc + 32'(4 * k));
                end
                m_pc = (m_pc | 32'hF) + 32'h1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit v;
        v = (mq_ins.size() != 0);
        chk("m_valid", 32'(instr_valid), 32'(v));
        chk("m_count", 32'(queue_count), 32'(mq_ins.size()));
        chk("m_rom_addr", rom_addr, m_pc);
        chk("m_instr", instr, v ? mq_ins[0] : 32'h0);
        chk("m_pc", instr_pc, v ? mq_pc[0] : 32'h0);
    endtask

    task automatic apply(input logic r, input logic j, input logic [31:0] ja, input logic rd);
        rst         = r;
        jmp_en      = j;
        jmp_addr    = ja;
        instr_ready = rd;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        j;
        logic [31:0] ja;
        logic        rd;
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        int          cnt;
        logic [31:0] ra;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic j, input logic [31:0] ja,
                                input logic rd, input logic v, input logic [31:0] ins,
                                input logic [31:0] pc, input int cnt, input logic [31:0] ra);
        vec_t x;
        x.r = r; x.j = j; x.ja = ja; x.rd = rd;
        x.v = v; x.ins = ins; x.pc = pc; x.cnt = cnt; x.ra = ra;
        return x;
    endfunction

    vec_t vt [28];

    initial begin
        vt[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
        vt[1]  = mk(0, 0, 0, 0, 1, 32'h1000,     32'h0,        4, 32'h10);
        vt[2]  = mk(0, 0, 0, 0, 1, 32'h1000,     32'h0,        8, 32'h20);
        vt[3]  = mk(0, 0, 0, 0, 1, 32'h1000,     32'h0,        8, 32'h20);
        vt[4]  = mk(0, 0, 0, 1, 1, 32'h1000,     32'h0,        8, 32'h20);
        vt[5]  = mk(0, 0, 0, 1, 1, 32'h1001,     32'h4,        7, 32'h20);
        vt[6]  = mk(0, 0, 0, 1, 1, 32'h1002,     32'h8,        6, 32'h20);
        vt[7]  = mk(0, 0, 0, 1, 1, 32'h1003,     32'hC,        5, 32'h20);
        vt[8]  = mk(0, 0, 0, 1, 1, 32'h1004,     32'h10,       4, 32'h20);
        vt[9]  = mk(0, 0, 0, 1, 1, 32'h1005,     32'h14,       7, 32'h30);
        vt[10] = mk(0, 0, 0, 1, 1, 32'h1006,     32'h18,       6, 32'h30);
        vt[11] = mk(0, 1, 32'h2A, 1, 1, 32'h1007, 32'h1C,      5, 32'h30);
        vt[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h28);
        vt[13] = mk(0, 0, 0, 1, 1, 32'h100A,     32'h28,       2, 32'h30);
        vt[14] = mk(0, 0, 0, 1, 1, 32'h100B,     32'h2C,       5, 32'h40);
        vt[15] = mk(0, 0, 0, 1, 1, 32'h100C,     32'h30,       4, 32'h40);
        vt[16] = mk(0, 1, 32'h3F, 1, 1, 32'h100D, 32'h34,      7, 32'h50);
        vt[17] = mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h3C);
        vt[18] = mk(0, 0, 0, 1, 1, 32'h100F,     32'h3C,       1, 32'h40);
        vt[19] = mk(0, 1, 32'h0, 1, 1, 32'h1010, 32'h40,       4, 32'h50);
        vt[20] = mk(0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 32'h0);
        vt[21] = mk(0, 0, 0, 1, 1, 32'h1000,     32'h0,        4, 32'h10);
        vt[22] = mk(1, 0, 0, 1, 1, 32'h1001,     32'h4,        7, 32'h20);
        vt[23] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0);
        vt[24] = mk(0, 0, 0, 0, 1, 32'h1000,     32'h0,        4, 32'h10);
        vt[25] = mk(0, 1, 32'hFFFF_FFF6, 0, 1, 32'h1000, 32'h0, 8, 32'h20);
        vt[26] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'hFFFF_FFF4);
        vt[27] = mk(0, 0, 0, 0, 1, 32'h4000_0FFD, 32'hFFFF_FFF4, 3, 32'h0);

        rst = 1'b1; jmp_en = 1'b0; jmp_addr = '0; instr_ready = 1'b0;
        m_pc = 32'h0;
        apply(1, 0, 0, 0); advance();
        apply(1, 0, 0, 0); advance();

        for (int i = 0; i < 28; i++) begin
            apply(vt[i].r, vt[i].j, vt[i].ja, vt[i].rd);
            chk($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(vt[i].v));
            chk($sformatf("t%0d_instr", i), instr, vt[i].ins);
            chk($sformatf("t%0d_pc", i), instr_pc, vt[i].pc);
            chk($sformatf("t%0d_count", i), 32'(queue_count), 32'(vt[i].cnt));
            chk($sformatf("t%0d_rom", i), rom_addr, vt[i].ra);
            advance();
        end

        for (int i = 0; i < 3000; i++) begin
            logic        r, j, rd;
            logic [31:0] ja;
            r  = ($urandom_range(0, 199) == 0);
            j  = ($urandom_range(0, 15) == 0);
            rd = ($urandom_range(0, 9) < 6);
            ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                             : $urandom;
            apply(r, j, ja, rd);
            model_check();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
